// File: rtl/seq_match_logger.sv
// Logs the bit position of every 0110 detector match into a show-ahead FIFO drained by the DSP,
// with a saturating match counter, sticky overflow flag and registered interrupt level.
module seq_match_logger #(
   parameter int unsigned POS_W     = 16,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned IRQ_LEVEL = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     match_in,
   input  logic                     clr,
   output logic [POS_W-1:0]         pos_data,
   output logic                     pos_valid,
   input  logic                     pos_ready,
   output logic [CNT_W-1:0]         match_count,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     irq
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] DepthL = LW'(DEPTH);
   localparam logic [LW-1:0] IrqL   = LW'(IRQ_LEVEL);

   logic [POS_W-1:0] mem_q [DEPTH];
   logic [POS_W-1:0] bit_pos_q, bit_pos_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, irq_q, irq_d;
   logic             push, pop, accept;

   assign pos_valid   = (level_q != '0);
   assign pos_data    = pos_valid ? mem_q[rd_ptr_q] : '0;
   assign match_count = cnt_q;
   assign level       = level_q;
   assign overflow    = ovf_q;
   assign irq         = irq_q;

   always_comb begin
      // clr suppresses this cycle's match and any pop
      push   = en & match_in & ~clr;
      pop    = pos_valid & pos_ready & ~clr;
      accept = push & ((level_q < DepthL) | pop);

      bit_pos_d = bit_pos_q + POS_W'(en);
      wr_ptr_d  = wr_ptr_q + AW'(accept);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      level_d   = level_q + LW'(accept) - LW'(pop);
      ovf_d     = ovf_q | (push & ~accept);
      cnt_d     = cnt_q;
      if (push && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

      if (clr) begin
         bit_pos_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         ovf_d     = 1'b0;
         cnt_d     = '0;
      end
      irq_d = ~clr & ((level_d >= IrqL) | ovf_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_pos_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         bit_pos_q <= bit_pos_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         irq_q     <= irq_d;
      end
   end

   // Storage needs no reset: contents are only visible while level is non-zero.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= bit_pos_q;
   end

endmodule
